// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_WAIT = 3'd2,
        RD_CAP  = 3'd3,
        WR      = 3'd4,
        DONE    = 3'd5
    } state_t;

    // Cycles spent in RD_ADDR..RD_CAP before the DONE cycle.
    localparam int RD_LATENCY = 3;

    function automatic logic misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester/memory-side bundle of the port arbiter; master drives requests, slave is the arbiter.
interface mem_port_arbiter_if;
    import mem_arb_pkg::*;

    // Requester holds req and operands until its done pulse; done is a single-cycle strobe.
    logic        req_if;
    logic [31:0] addr_if;
    logic        req_dt;
    logic        dt_we;
    logic [31:0] addr_dt;
    logic [31:0] wdata_dt;
    logic [31:0] mem_rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        gnt_if;
    logic        gnt_dt;
    logic        done_if;
    logic        done_dt;
    logic [31:0] rdata;
    logic        addr_err;
    logic        busy;
    state_t      state;

    modport master (
        output req_if, addr_if, req_dt, dt_we, addr_dt, wdata_dt, mem_rdata,
        input  mem_addr, mem_wdata, mem_we, gnt_if, gnt_dt, done_if, done_dt,
               rdata, addr_err, busy, state
    );

    modport slave (
        input  req_if, addr_if, req_dt, dt_we, addr_dt, wdata_dt, mem_rdata,
        output mem_addr, mem_wdata, mem_we, gnt_if, gnt_dt, done_if, done_dt,
               rdata, addr_err, busy, state
    );

endinterface

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: combinational winner, last_gnt updated when a grant is taken.
module rr_pick2 (
    input  logic clock,
    input  logic reset,
    input  logic req_if,
    input  logic req_dt,
    input  logic take,
    output logic any_req,
    output logic win_dt
);

    // 1 = data port won last; reset to data so fetch wins the first tie.
    logic last_gnt;

    always_comb begin
        any_req = req_if | req_dt;
        win_dt  = req_dt;
        if (req_if && req_dt) begin
            win_dt = ~last_gnt;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_gnt <= 1'b1;
        end else if (take) begin
            last_gnt <= win_dt;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between an instruction-fetch and a data requester.
module mem_port_arbiter
    import mem_arb_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);

    state_t      state_q;
    state_t      state_d;
    logic        any_req;
    logic        win_dt;
    logic        take;
    logic        own_dt_q;
    logic        mis_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [31:0] pick_addr;

    rr_pick2 u_pick (
        .clock   (clock),
        .reset   (reset),
        .req_if  (bus.req_if),
        .req_dt  (bus.req_dt),
        .take    (take),
        .any_req (any_req),
        .win_dt  (win_dt)
    );

    assign take      = (state_q == IDLE) && any_req;
    assign pick_addr = win_dt ? bus.addr_dt : bus.addr_if;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            own_dt_q <= 1'b0;
            mis_q    <= 1'b0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            if (take) begin
                own_dt_q <= win_dt;
                mis_q    <= misaligned(pick_addr[1:0]);
                addr_q   <= pick_addr;
                wdata_q  <= win_dt ? bus.wdata_dt : 32'd0;
            end
            if (state_q == RD_CAP) begin
                rdata_q <= bus.mem_rdata;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        bus.state     = state_q;
        bus.busy      = (state_q != IDLE);
        bus.rdata     = rdata_q;
        bus.mem_addr  = 32'd0;
        bus.mem_wdata = 32'd0;
        bus.mem_we    = 1'b0;
        bus.gnt_if    = 1'b0;
        bus.gnt_dt    = 1'b0;
        bus.done_if   = 1'b0;
        bus.done_dt   = 1'b0;
        bus.addr_err  = 1'b0;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    // A fetch never writes, whatever dt_we says.
                    if (misaligned(pick_addr[1:0]))  state_d = DONE;
                    else if (win_dt && bus.dt_we)    state_d = WR;
                    else                             state_d = RD_ADDR;
                end
            end
            RD_ADDR: state_d = RD_WAIT;
            RD_WAIT: state_d = RD_CAP;
            RD_CAP:  state_d = DONE;
            WR:      state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (state_q != IDLE) begin
            bus.gnt_if = ~own_dt_q;
            bus.gnt_dt = own_dt_q;
            if (!mis_q) begin
                bus.mem_addr = addr_q;
            end
        end
        if (state_q == WR) begin
            bus.mem_we    = 1'b1;
            bus.mem_wdata = wdata_q;
        end
        if (state_q == DONE) begin
            bus.done_if  = ~own_dt_q;
            bus.done_dt  = own_dt_q;
            bus.addr_err = mis_q;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: per-access expected-cycle schedule checked every cycle,
// plus directed scenarios with hand-computed latencies and data.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    typedef struct {
        state_t      st;
        logic        gnt_if;
        logic        gnt_dt;
        logic        done_if;
        logic        done_dt;
        logic        addr_err;
        logic        mem_we;
        logic        cap;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    mem_port_arbiter_if bus ();

    mem_port_arbiter dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    exp_t        exp_q[$];
    logic        m_last_dt = 1'b1;
    logic [31:0] m_rdata   = 32'd0;
    logic [31:0] rd_value  = 32'd0;
    logic [15:0] junk_ctr  = 16'd0;
    int          n_vec     = 0;
    int          n_err     = 0;
    int          we_cycles = 0;
    int          done_cycles = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    function automatic exp_t idle_rec();
        exp_t r;
        r.st        = IDLE;
        r.gnt_if    = 1'b0;
        r.gnt_dt    = 1'b0;
        r.done_if   = 1'b0;
        r.done_dt   = 1'b0;
        r.addr_err  = 1'b0;
        r.mem_we    = 1'b0;
        r.cap       = 1'b0;
        r.mem_addr  = 32'd0;
        r.mem_wdata = 32'd0;
        return r;
    endfunction

    function automatic logic pick_dt(input logic rq_if, input logic rq_dt, input logic last_dt);
        return rq_dt && (!rq_if || !last_dt);
    endfunction

    // Queue every cycle the granted access will occupy, from grant+1 through its done cycle.
    function automatic void plan_access(input logic dt);
        exp_t        r;
        logic [31:0] a;
        a = dt ? bus.addr_dt : bus.addr_if;
        r = idle_rec();
        r.gnt_if = !dt;
        r.gnt_dt = dt;
        if (a[1:0] != 2'b00) begin
            r.st       = DONE;
            r.done_if  = !dt;
            r.done_dt  = dt;
            r.addr_err = 1'b1;
            exp_q.push_back(r);
            return;
        end
        r.mem_addr = a;
        if (dt && bus.dt_we) begin
            r.st        = WR;
            r.mem_we    = 1'b1;
            r.mem_wdata = bus.wdata_dt;
            exp_q.push_back(r);
            r.mem_we    = 1'b0;
            r.mem_wdata = 32'd0;
        end else begin
            for (int k = 0; k < RD_LATENCY; k++) begin
                if (k == 0)                   r.st = RD_ADDR;
                else if (k == RD_LATENCY - 1) r.st = RD_CAP;
                else                          r.st = RD_WAIT;
                r.cap = (k == RD_LATENCY - 1);
                exp_q.push_back(r);
            end
            r.cap = 1'b0;
        end
        r.st      = DONE;
        r.done_if = !dt;
        r.done_dt = dt;
        exp_q.push_back(r);
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            exp_q.delete();
            m_last_dt <= 1'b1;
            m_rdata   <= 32'd0;
        end else if (exp_q.size() != 0) begin
            if (exp_q[0].cap) m_rdata <= bus.mem_rdata;
            void'(exp_q.pop_front());
        end else if (bus.req_if || bus.req_dt) begin
            m_last_dt <= pick_dt(bus.req_if, bus.req_dt, m_last_dt);
            plan_access(pick_dt(bus.req_if, bus.req_dt, m_last_dt));
        end
    end

    // Memory returns the intended word only in the capture cycle, junk otherwise.
    always @(posedge clock) begin
        #1;
        junk_ctr++;
        if (exp_q.size() != 0 && exp_q[0].cap) bus.mem_rdata = rd_value;
        else                                   bus.mem_rdata = {16'hBAD0, junk_ctr};
    end

    always @(negedge clock) begin
        exp_t e;
        if (exp_q.size() != 0) e = exp_q[0];
        else                   e = idle_rec();
        check("cyc.state",     32'(bus.state), 32'(e.st));
        check("cyc.busy",      32'(bus.busy), 32'(e.st != IDLE));
        check("cyc.gnt_if",    32'(bus.gnt_if), 32'(e.gnt_if));
        check("cyc.gnt_dt",    32'(bus.gnt_dt), 32'(e.gnt_dt));
        check("cyc.done_if",   32'(bus.done_if), 32'(e.done_if));
        check("cyc.done_dt",   32'(bus.done_dt), 32'(e.done_dt));
        check("cyc.addr_err",  32'(bus.addr_err), 32'(e.addr_err));
        check("cyc.mem_we",    32'(bus.mem_we), 32'(e.mem_we));
        check("cyc.mem_addr",  bus.mem_addr, e.mem_addr);
        check("cyc.mem_wdata", bus.mem_wdata, e.mem_wdata);
        check("cyc.rdata",     bus.rdata, m_rdata);
        if (bus.mem_we === 1'b1) we_cycles++;
        if (bus.done_if === 1'b1 || bus.done_dt === 1'b1) done_cycles++;
    end

    task automatic sync();
        @(posedge clock);
        #1;
    endtask

    // Counts edges from the current point until the chosen done pulse is seen; -1 on timeout.
    task automatic wait_done(input logic dt, output int cyc);
        cyc = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock);
            cyc++;
            @(negedge clock);
            if ((dt ? bus.done_dt : bus.done_if) === 1'b1) return;
        end
        cyc = -1;
    endtask

    task automatic req_fetch(input logic [31:0] a);
        bus.req_if  = 1'b1;
        bus.addr_if = a;
    endtask

    task automatic req_data(input logic we, input logic [31:0] a, input logic [31:0] d);
        bus.req_dt   = 1'b1;
        bus.dt_we    = we;
        bus.addr_dt  = a;
        bus.wdata_dt = d;
    endtask

    initial begin
        int cyc;
        int base_we;
        int base_done;
        bus.req_if    = 1'b0;
        bus.addr_if   = 32'd0;
        bus.req_dt    = 1'b0;
        bus.dt_we     = 1'b0;
        bus.addr_dt   = 32'd0;
        bus.wdata_dt  = 32'd0;
        bus.mem_rdata = 32'd0;

        repeat (2) @(posedge clock);
        check("rst_state", 32'(bus.state), 32'(IDLE));
        check("rst_rdata", bus.rdata, 32'd0);
        check("rst_outs", {bus.gnt_if, bus.gnt_dt, bus.done_if, bus.done_dt, bus.addr_err, bus.mem_we},
              32'd0);
        #1 reset = 1'b0;

        // Fetch read with data-side write qualifiers set but no data request.
        sync();
        bus.dt_we    = 1'b1;
        bus.wdata_dt = 32'h1111_2222;
        rd_value     = 32'h8C01_0004;
        base_we      = we_cycles;
        req_fetch(32'h0000_0040);
        wait_done(1'b0, cyc);
        check("fetch_latency", cyc, 32'd4);
        check("fetch_rdata", bus.rdata, 32'h8C01_0004);
        check("fetch_addr_err", 32'(bus.addr_err), 32'd0);
        bus.req_if = 1'b0;
        bus.dt_we  = 1'b0;
        check("fetch_no_write", we_cycles - base_we, 32'd0);

        // Data write, then a back-to-back data read without dropping req_dt.
        sync();
        base_we = we_cycles;
        req_data(1'b1, 32'h0000_0100, 32'hDEAD_BEEF);
        @(posedge clock);
        @(negedge clock);
        check("wr_mem_we", 32'(bus.mem_we), 32'd1);
        check("wr_mem_addr", bus.mem_addr, 32'h0000_0100);
        check("wr_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
        wait_done(1'b1, cyc);
        check("wr_done_latency", cyc, 32'd1);
        check("wr_one_we_cycle", we_cycles - base_we, 32'd1);
        check("wr_rdata_kept", bus.rdata, 32'h8C01_0004);
        rd_value = 32'h0BAD_F00D;
        req_data(1'b0, 32'h0000_0104, 32'd0);
        wait_done(1'b1, cyc);
        check("b2b_latency", cyc, 32'd5);
        check("b2b_rdata", bus.rdata, 32'h0BAD_F00D);
        bus.req_dt = 1'b0;

        // Misaligned data write.
        sync();
        base_we = we_cycles;
        req_data(1'b1, 32'h0000_0102, 32'hCAFE_0001);
        wait_done(1'b1, cyc);
        check("mis_latency", cyc, 32'd1);
        check("mis_addr_err", 32'(bus.addr_err), 32'd1);
        check("mis_mem_addr", bus.mem_addr, 32'd0);
        check("mis_rdata_kept", bus.rdata, 32'h0BAD_F00D);
        bus.req_dt = 1'b0;
        check("mis_no_write", we_cycles - base_we, 32'd0);

        // Ties straight after reset alternate, fetch first.
        sync();
        reset = 1'b1;
        sync();
        reset = 1'b0;
        rd_value = 32'hA5A5_0001;
        req_fetch(32'h0000_0080);
        req_data(1'b0, 32'h0000_0200, 32'd0);
        wait_done(1'b0, cyc);
        check("tie1_fetch_latency", cyc, 32'd4);
        check("tie1_gnt_dt", 32'(bus.gnt_dt), 32'd0);
        check("tie1_rdata", bus.rdata, 32'hA5A5_0001);
        bus.req_if = 1'b0;
        rd_value   = 32'hA5A5_0002;
        wait_done(1'b1, cyc);
        check("tie1_data_latency", cyc, 32'd5);
        check("tie1_data_rdata", bus.rdata, 32'hA5A5_0002);
        rd_value = 32'hA5A5_0003;
        req_fetch(32'h0000_0084);
        wait_done(1'b0, cyc);
        check("tie2_fetch_latency", cyc, 32'd5);
        check("tie2_rdata", bus.rdata, 32'hA5A5_0003);
        bus.req_if = 1'b0;
        wait_done(1'b1, cyc);
        check("tie2_data_latency", cyc, 32'd5);
        bus.req_dt = 1'b0;

        // Reset during RD_WAIT aborts the read; the next tie goes to fetch.
        sync();
        rd_value = 32'h7777_7777;
        req_fetch(32'h0000_0300);
        @(posedge clock);
        @(posedge clock);
        #1;
        check("pre_rst_state", 32'(bus.state), 32'(RD_WAIT));
        base_done = done_cycles;
        reset = 1'b1;
        #1;
        check("rst_rdwait_state", 32'(bus.state), 32'(IDLE));
        check("rst_rdwait_gnt", 32'(bus.gnt_if), 32'd0);
        bus.req_if = 1'b0;
        sync();
        reset = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        check("rst_no_done", done_cycles - base_done, 32'd0);
        check("rst_rdata_cleared", bus.rdata, 32'd0);
        rd_value = 32'h4444_0044;
        req_fetch(32'h0000_0044);
        req_data(1'b1, 32'h0000_0208, 32'h0102_0304);
        wait_done(1'b0, cyc);
        check("post_rst_tie_fetch", cyc, 32'd4);
        check("post_rst_rdata", bus.rdata, 32'h4444_0044);
        bus.req_if = 1'b0;
        wait_done(1'b1, cyc);
        check("post_rst_data_wr", cyc, 32'd3);
        bus.req_dt = 1'b0;

        // Reset during WR drops mem_we without waiting for a clock.
        sync();
        req_data(1'b1, 32'h0000_010C, 32'h1234_5678);
        sync();
        check("pre_rst_we", 32'(bus.mem_we), 32'd1);
        reset = 1'b1;
        #1;
        check("rst_wr_we", 32'(bus.mem_we), 32'd0);
        check("rst_wr_state", 32'(bus.state), 32'(IDLE));
        bus.req_dt = 1'b0;
        sync();
        reset = 1'b0;

        // Fetch request withdrawn in RD_ADDR still completes.
        sync();
        rd_value = 32'h5555_AAAA;
        req_fetch(32'h0000_0050);
        sync();
        bus.req_if = 1'b0;
        check("drop_state", 32'(bus.state), 32'(RD_ADDR));
        wait_done(1'b0, cyc);
        check("drop_latency", cyc, 32'd3);
        check("drop_rdata", bus.rdata, 32'h5555_AAAA);

        repeat (3) @(posedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at 32-bit address/data.
REQ-002 clock  in  1  rising-edge clock, named clock.
REQ-003 reset  in  1  reset, asynchronous, active-high, named reset.
REQ-004 req_if  in  1  instruction-fetch request (always a read).
REQ-005 addr_if  in  32  fetch byte address.
REQ-006 req_dt  in  1  data-access request.
REQ-007 dt_we  in  1  data access is a write (1) or read (0).
REQ-008 addr_dt  in  32  data byte address.
REQ-009 wdata_dt  in  32  data write value.
REQ-010 mem_rdata  in  32  memory read data.
REQ-011 mem_addr  out  32  memory address.
REQ-012 mem_wdata  out  32  memory write data.
REQ-013 mem_we  out  1  memory write enable.
REQ-014 gnt_if / gnt_dt  out  1 each  requester owns the port.
REQ-015 done_if / done_dt  out  1 each  one-cycle completion pulse.
REQ-016 rdata  out  32  registered read result.
REQ-017 addr_err  out  1  completion carries a misalignment error.
REQ-018 busy  out  1  state != IDLE.
REQ-019 state  out  3  current FSM state, for debug visibility.

Function
REQ-020 The FSM SHALL have states IDLE, RD_ADDR, RD_WAIT, RD_CAP, WR, DONE.
REQ-021 IDLE transitions, evaluated on each clock edge:
  - no request: remain in IDLE.
  - request present: latch winner, address, dt_we and wdata_dt.
  - next state: DONE if latched addr[1:0]!=0, else WR for a data write, else RD_ADDR.
REQ-022 Arbitration SHALL be round-robin with a 1-bit last_gnt register.
  - A sole requester wins.
  - If both request, the requester not equal to last_gnt wins.
  - last_gnt updates at grant.
REQ-023 Read path SHALL be RD_ADDR -> RD_WAIT -> RD_CAP -> DONE.
  - rdata loads mem_rdata at the edge ending RD_CAP.
  - Done is therefore asserted 4 cycles after the IDLE sampling edge.
REQ-024 Write path SHALL be WR -> DONE; mem_we=1 only in WR; mem_wdata = latched data in WR, else 0.
REQ-025 mem_addr SHALL be the latched address in every state except IDLE and misaligned DONE, where it is 0.
REQ-026 In DONE the block SHALL:
  - pulse done_x for the latched winner only;
  - assert addr_err if the access was misaligned;
  - then return to IDLE.
REQ-027 Misaligned accesses SHALL:
  - never assert mem_we;
  - never touch memory;
  - leave rdata unchanged.
REQ-028 gnt_x SHALL be high from the cycle after the grant edge through DONE inclusive.
REQ-029 rdata SHALL hold its value until the next successful read capture; writes do not modify it.
REQ-030 Requester obligations:
  - hold req and operands until done;
  - deassert req in the cycle after done unless issuing a new access.
REQ-031 Back-to-back accesses SHALL be accepted with one IDLE cycle between DONE and the next grant.
REQ-032 If req drops after grant, the latched access SHALL still complete and done SHALL still pulse.
REQ-033 Fetch requests SHALL ignore dt_we and wdata_dt.

Reset
REQ-034 Reset SHALL force state=IDLE and last_gnt=data (fetch wins the first tie), with all outputs 0 (rdata=0, mem_we=0, done/gnt/addr_err=0).
REQ-035 Reset mid-operation SHALL abort the access immediately: mem_we drops asynchronously, no done pulse is produced, and the latched request is discarded.

Structure
REQ-036 Package mem_arb_pkg SHALL hold the state enum (3-bit) and constant RD_LATENCY=3 (RD_ADDR..RD_CAP).
REQ-037 Round-robin selection SHALL be sub-module rr_pick2 (combinational winner plus last_gnt register).

Verification
REQ-038 Fetch read: req_if=1, addr_if=0x40, mem_rdata=0x8C010004 in RD_CAP -> done_if pulses on cycle 4, rdata=0x8C010004, addr_err=0.
REQ-039 Data write: req_dt=1, dt_we=1, addr_dt=0x100, wdata=0xDEADBEEF -> exactly one cycle with mem_we=1, mem_addr=0x100, mem_wdata=0xDEADBEEF, then done_dt.
REQ-040 Simultaneous requests after reset -> fetch granted first, data second; repeat the tie -> fetch again (alternation).
REQ-041 Misaligned: addr_dt=0x102 write -> mem_we never high, done_dt with addr_err=1, rdata unchanged.
REQ-042 Reset asserted during RD_WAIT -> state=IDLE immediately, no done pulse, next tie goes to fetch.
REQ-043 req_if dropped in RD_ADDR -> read still completes, done_if pulses.
